// File: rtl/piso_serializer.sv
// Parallel-in/serial-out shifter: valid/ready word input, one-word holding buffer,
// DIV-cycle bit period and gap-free streaming of back-to-back words.
module piso_serializer #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned DIV        = 1,
    parameter bit          LSB_FIRST  = 1'b0,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_din_valid,
    output logic             o_din_ready,
    output logic             o_sout,
    output logic             o_sframe,
    output logic             o_bit_strobe,
    output logic             o_word_done,
    output logic             o_busy
);
    localparam int unsigned BCW = $clog2(WIDTH);
    localparam int unsigned DCW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BCW-1:0] BIT_LAST = BCW'(WIDTH - 1);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);

    typedef enum logic {StIdle, StShift} state_e;

    state_e           r_state, w_state_next;
    logic [WIDTH-1:0] r_hold, w_hold_next;
    logic             r_hold_full, w_hold_full_next;
    logic [WIDTH-1:0] r_sreg, w_sreg_next;
    logic [BCW-1:0]   r_bit_cnt, w_bit_cnt_next;
    logic [DCW-1:0]   r_div_cnt, w_div_cnt_next;
    logic             r_sout, w_sout_next;
    logic             r_din_ready;
    logic             w_accept;
    logic             w_last_bit;
    logic [WIDTH-1:0] w_shifted;

    assign w_accept   = i_din_valid && r_din_ready;
    assign w_last_bit = (r_bit_cnt == BIT_LAST) && (r_div_cnt == DIV_LAST);
    assign w_shifted  = LSB_FIRST ? {1'b0, r_sreg[WIDTH-1:1]} : {r_sreg[WIDTH-2:0], 1'b0};

    always_comb begin
        w_state_next     = r_state;
        w_hold_next      = r_hold;
        w_hold_full_next = r_hold_full;
        w_sreg_next      = r_sreg;
        w_bit_cnt_next   = r_bit_cnt;
        w_div_cnt_next   = r_div_cnt;

        unique case (r_state)
            StIdle: begin
                if (r_hold_full) begin
                    w_sreg_next      = r_hold;
                    w_hold_full_next = 1'b0;
                    w_bit_cnt_next   = '0;
                    w_div_cnt_next   = '0;
                    w_state_next     = StShift;
                end
            end
            StShift: begin
                if (r_div_cnt != DIV_LAST) begin
                    w_div_cnt_next = r_div_cnt + DCW'(1);
                end else if (w_last_bit) begin
                    // Reload straight from hold so consecutive words leave no idle gap
                    w_bit_cnt_next = '0;
                    w_div_cnt_next = '0;
                    if (r_hold_full) begin
                        w_sreg_next      = r_hold;
                        w_hold_full_next = 1'b0;
                    end else begin
                        w_sreg_next  = '0;
                        w_state_next = StIdle;
                    end
                end else begin
                    w_div_cnt_next = '0;
                    w_sreg_next    = w_shifted;
                    w_bit_cnt_next = r_bit_cnt + BCW'(1);
                end
            end
            default: w_state_next = StIdle;
        endcase

        // Accept never coincides with a transfer: ready is low whenever hold is full
        if (w_accept) begin
            w_hold_next      = i_din;
            w_hold_full_next = 1'b1;
        end

        w_sout_next = IDLE_LEVEL;
        if (w_state_next == StShift) begin
            w_sout_next = LSB_FIRST ? w_sreg_next[0] : w_sreg_next[WIDTH-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= StIdle;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_sreg      <= '0;
            r_bit_cnt   <= '0;
            r_div_cnt   <= '0;
            r_sout      <= IDLE_LEVEL;
            r_din_ready <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_hold      <= w_hold_next;
            r_hold_full <= w_hold_full_next;
            r_sreg      <= w_sreg_next;
            r_bit_cnt   <= w_bit_cnt_next;
            r_div_cnt   <= w_div_cnt_next;
            r_sout      <= w_sout_next;
            r_din_ready <= !w_hold_full_next;
        end
    end

    assign o_din_ready  = r_din_ready;
    assign o_sout       = r_sout;
    assign o_sframe     = (r_state == StShift);
    assign o_bit_strobe = o_sframe && (r_div_cnt == '0);
    assign o_word_done  = o_sframe && w_last_bit;
    assign o_busy       = o_sframe || r_hold_full;

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: five parameter sets behind one output mux, checked every cycle
// against a word-queue/timeline reference model, vector tables and a word scoreboard.
`timescale 1ns/1ps
module tb_piso_serializer;
    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [31:0] tb_din;
    logic        tb_valid;
    int          sel;

    logic ready_v [5];
    logic sout_v  [5];
    logic frame_v [5];
    logic strb_v  [5];
    logic done_v  [5];
    logic busy_v  [5];

    piso_serializer #(.WIDTH(8), .DIV(3), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_a (
        .i_clk(clk), .i_rst_n(rst_n), .i_din(tb_din[7:0]), .i_din_valid(tb_valid && sel == 0),
        .o_din_ready(ready_v[0]), .o_sout(sout_v[0]), .o_sframe(frame_v[0]),
        .o_bit_strobe(strb_v[0]), .o_word_done(done_v[0]), .o_busy(busy_v[0]));
    piso_serializer #(.WIDTH(8), .DIV(1), .LSB_FIRST(1'b1), .IDLE_LEVEL(1'b1)) u_b (
        .i_clk(clk), .i_rst_n(rst_n), .i_din(tb_din[7:0]), .i_din_valid(tb_valid && sel == 1),
        .o_din_ready(ready_v[1]), .o_sout(sout_v[1]), .o_sframe(frame_v[1]),
        .o_bit_strobe(strb_v[1]), .o_word_done(done_v[1]), .o_busy(busy_v[1]));
    piso_serializer #(.WIDTH(8), .DIV(1), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_c (
        .i_clk(clk), .i_rst_n(rst_n), .i_din(tb_din[7:0]), .i_din_valid(tb_valid && sel == 2),
        .o_din_ready(ready_v[2]), .o_sout(sout_v[2]), .o_sframe(frame_v[2]),
        .o_bit_strobe(strb_v[2]), .o_word_done(done_v[2]), .o_busy(busy_v[2]));
    piso_serializer #(.WIDTH(32), .DIV(2), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_d (
        .i_clk(clk), .i_rst_n(rst_n), .i_din(tb_din), .i_din_valid(tb_valid && sel == 3),
        .o_din_ready(ready_v[3]), .o_sout(sout_v[3]), .o_sframe(frame_v[3]),
        .o_bit_strobe(strb_v[3]), .o_word_done(done_v[3]), .o_busy(busy_v[3]));
    piso_serializer #(.WIDTH(16), .DIV(4), .LSB_FIRST(1'b0), .IDLE_LEVEL(1'b0)) u_e (
        .i_clk(clk), .i_rst_n(rst_n), .i_din(tb_din[15:0]), .i_din_valid(tb_valid && sel == 4),
        .o_din_ready(ready_v[4]), .o_sout(sout_v[4]), .o_sframe(frame_v[4]),
        .o_bit_strobe(strb_v[4]), .o_word_done(done_v[4]), .o_busy(busy_v[4]));

    logic d_ready, d_sout, d_frame, d_strobe, d_done, d_busy;
    always_comb begin
        d_ready  = ready_v[sel];
        d_sout   = sout_v[sel];
        d_frame  = frame_v[sel];
        d_strobe = strb_v[sel];
        d_done   = done_v[sel];
        d_busy   = busy_v[sel];
    end
    logic [5:0] obs;
    assign obs = {d_ready, d_busy, d_sout, d_frame, d_strobe, d_done};

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
        end
    endtask

    // Reference model: pending words in a queue, the word on the line and its cycle offset
    int unsigned cw, cd;
    bit          clsb, cidle;
    logic [31:0] cmask;
    logic [31:0] mq[$];
    logic [31:0] cur;
    int unsigned t;
    bit          active, mrdy;

    task automatic set_cfg(input int s);
        case (s)
            0:       begin cw = 8;  cd = 3; clsb = 0; cidle = 0; end
            1:       begin cw = 8;  cd = 1; clsb = 1; cidle = 1; end
            2:       begin cw = 8;  cd = 1; clsb = 0; cidle = 0; end
            3:       begin cw = 32; cd = 2; clsb = 0; cidle = 0; end
            default: begin cw = 16; cd = 4; clsb = 0; cidle = 0; end
        endcase
        cmask = (cw >= 32) ? 32'hFFFF_FFFF : ((32'd1 << cw) - 32'd1);
    endtask

    task automatic model_reset(input bit rdy);
        mq.delete();
        active = 0;
        t      = 0;
        cur    = '0;
        mrdy   = rdy;
    endtask

    function automatic logic [5:0] model_exp();
        logic        b;
        int unsigned idx;
        b = cidle;
        if (active) begin
            idx = t / cd;
            b   = clsb ? cur[idx] : cur[cw-1-idx];
        end
        return {mrdy, active || (mq.size() > 0), b, active, active && (t % cd == 0),
                active && (t == cw * cd - 1)};
    endfunction

    task automatic model_edge(input bit v, input logic [31:0] d);
        bit acc;
        acc = v && mrdy;
        if (active) begin
            if (t == cw * cd - 1) begin
                if (mq.size() > 0) begin
                    cur = mq.pop_front();
                    t   = 0;
                end else begin
                    active = 0;
                end
            end else begin
                t++;
            end
        end else if (mq.size() > 0) begin
            cur    = mq.pop_front();
            active = 1;
            t      = 0;
        end
        if (acc) mq.push_back(d & cmask);
        mrdy = (mq.size() == 0);
    endtask

    // Scoreboard: words seen on the DUT handshake vs words reassembled from sout
    logic [31:0] sb_q[$];
    logic [31:0] sb_acc;
    int          sb_n, sb_words, n_acc;

    task automatic sb_reset();
        sb_q.delete();
        sb_acc   = '0;
        sb_n     = 0;
        sb_words = 0;
    endtask

    // Called at a falling edge: drive inputs, check this cycle, advance one clock
    task automatic step(input bit v, input logic [31:0] d);
        tb_valid = v;
        tb_din   = d;
        check("cycle", {26'd0, obs}, {26'd0, model_exp()});
        if (v && d_ready) begin
            sb_q.push_back(d & cmask);
            n_acc++;
        end
        if (d_frame && d_strobe) begin
            if (clsb) sb_acc[sb_n] = d_sout;
            else      sb_acc = {sb_acc[30:0], d_sout};
            sb_n++;
        end
        if (d_frame && d_done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL word_unexpected at %0t: got %h, expected no word", $time, sb_acc);
            end else begin
                check("word", sb_acc, sb_q.pop_front());
            end
            sb_words++;
            sb_acc = '0;
            sb_n   = 0;
        end
        model_edge(v, d);
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit          v;
        logic [31:0] d;
        logic [5:0]  e;
    } vec_t;
    vec_t tbl[$];

    // Vector table for one isolated word; seq holds the bits in transmission order
    task automatic build_single(input logic [31:0] word, input logic [0:7] seq);
        tbl.delete();
        tbl.push_back('{v: 1'b1, d: word, e: {1'b1, 1'b0, cidle, 3'b000}});
        tbl.push_back('{v: 1'b0, d: 32'd0, e: {1'b0, 1'b1, cidle, 3'b000}});
        for (int k = 0; k < int'(cw * cd); k++) begin
            tbl.push_back('{v: 1'b0, d: 32'd0,
                            e: {1'b1, 1'b1, seq[k/int'(cd)], 1'b1, (k % int'(cd)) == 0,
                                k == int'(cw * cd) - 1}});
        end
        tbl.push_back('{v: 1'b0, d: 32'd0, e: {1'b1, 1'b0, cidle, 3'b000}});
        tbl.push_back('{v: 1'b0, d: 32'd0, e: {1'b1, 1'b0, cidle, 3'b000}});
    endtask

    task automatic run_table(input string name);
        for (int i = 0; i < tbl.size(); i++) begin
            check(name, {26'd0, obs}, {26'd0, tbl[i].e});
            step(tbl[i].v, tbl[i].d);
        end
    endtask

    task automatic begin_test(input int s);
        sel = s;
        set_cfg(s);
        model_reset(1'b1);
        sb_reset();
        n_acc = 0;
        #1;
        @(negedge clk);
    endtask

    initial begin
        logic [7:0] words [3];
        int         idx, run, max_run, fc;
        bit         adv, got;

        tb_valid = 0;
        tb_din   = '0;
        sel      = 0;
        rst_n    = 0;
        set_cfg(0);
        model_reset(1'b0);
        sb_reset();
        n_acc = 0;

        // Reset held five cycles; every instance shows idle level and zeros
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            sel = s;
            set_cfg(s);
            #1;
            check("reset_outputs", {26'd0, obs}, {26'd0, 1'b0, 1'b0, cidle, 3'b000});
        end
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);
        for (int s = 0; s < 5; s++) begin
            sel = s;
            #1;
            check("ready_after_reset", {31'd0, d_ready}, 32'd1);
            @(negedge clk);
        end

        // Single word, MSB first, DIV=3
        begin_test(0);
        build_single(32'hA5, 8'b10100101);
        run_table("tbl_msb_a5");

        // Single word, LSB first, idle level high
        begin_test(1);
        build_single(32'h3C, 8'b00111100);
        run_table("tbl_lsb_3c");

        // Back-to-back words with valid held high
        begin_test(2);
        words   = '{8'hFF, 8'h00, 8'h81};
        idx     = 0;
        run     = 0;
        max_run = 0;
        for (int c = 0; c < 100; c++) begin
            if (d_frame) run++;
            else if (run > 0) begin
                if (run > max_run) max_run = run;
                run = 0;
            end
            adv = (idx < 3) && d_ready;
            step(idx < 3, (idx < 3) ? {24'd0, words[idx]} : 32'd0);
            if (adv) idx++;
            if (idx == 3 && !d_busy) break;
        end
        if (run > max_run) max_run = run;
        check("b2b_frame_run", max_run, 24);
        check("b2b_accepts", n_acc, 3);
        check("b2b_words", sb_words, 3);
        check("b2b_drained", {31'd0, d_busy}, 32'd0);

        // Reset in the middle of a word with a second word held
        begin_test(3);
        step(1'b1, 32'hDEAD_BEEF);
        got = 0;
        for (int c = 0; c < 200 && !got; c++) begin
            got = d_ready;
            step(1'b1, 32'h1234_5678);
        end
        check("mid_second_accepted", {31'd0, got}, 32'd1);
        fc = 0;
        for (int c = 0; c < 200; c++) begin
            if (d_frame) fc++;
            if (fc == 21) break;
            step(1'b0, 32'd0);
        end
        check("mid_reached_bit10", fc, 21);
        rst_n = 0;
        #1;
        check("mid_reset_now", {26'd0, obs}, 32'd0);
        model_reset(1'b0);
        sb_reset();
        @(negedge clk);
        @(negedge clk);
        check("mid_reset_held", {26'd0, obs}, 32'd0);
        rst_n = 1;
        step(1'b0, 32'd0);
        step(1'b1, 32'h0000_0001);
        for (int c = 0; c < 200; c++) begin
            step(1'b0, 32'd0);
            if (!d_busy) break;
        end
        check("mid_drained", {31'd0, d_busy}, 32'd0);
        check("mid_words_after", sb_words, 1);

        // Randomised valid gaps, 200 words
        begin_test(4);
        for (int c = 0; c < 30000 && n_acc < 200; c++) begin
            step($urandom_range(0, 3) != 0, $urandom);
        end
        check("rand_accepts", n_acc, 200);
        for (int c = 0; c < 300; c++) begin
            step(1'b0, 32'd0);
            if (!d_busy) break;
        end
        check("rand_drained", {31'd0, d_busy}, 32'd0);
        check("rand_words", sb_words, 200);
        check("rand_sb_empty", sb_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parametrised parallel-in/serial-out shifter with a valid/ready input handshake, a one-word holding buffer and a programmable bit-rate divider. It takes over from the fixed 31-bit load/shift register used to stream counter snapshots off-chip. It adds selectable bit order, an idle line level, framing and strobe outputs, and gap-free back-to-back words. It sits between the counter capture logic and the serial output pin.

## Interface
- `WIDTH`, 32: bits per word; legal range is 2 or more.
- `DIV`, 1: clock cycles per serial bit; legal range is 1 or more.
- `LSB_FIRST`, 0: 0 shifts out the MSB first, 1 shifts out the LSB first.
- `IDLE_LEVEL`, 0: `sout` level while no word is being sent.

Ports:
- `clk` in 1: single clock; all logic is on the rising edge.
- `rst_n` in 1: asynchronous active-low reset; deassertion is synchronous to `clk` upstream.
- `din` in WIDTH: word to serialise.
- `din_valid` in 1: `din` is offered.
- `din_ready` out 1: the holding buffer can accept a word.
- `sout` out 1: serial data (registered).
- `sframe` out 1: high for every cycle in which `sout` carries a data bit.
- `bit_strobe` out 1: one-cycle pulse on the first cycle of each bit period.
- `word_done` out 1: one-cycle pulse on the last cycle of a word's last bit period.
- `busy` out 1: SHIFT state active, or the holding buffer is full.

## Operation
- **Storage:**
  - Holding register `hold` plus a `hold_full` flag.
  - Shift register `sreg[WIDTH-1:0]`.
  - Bit counter `bit_cnt`, range 0..WIDTH-1, width clog2(WIDTH).
  - Divider counter `div_cnt`, range 0..DIV-1, width max(1, clog2(DIV)).
- **Accept:** a word is accepted on an edge where `din_valid && din_ready`. It is written to `hold` and `hold_full` is set.
- **`din_ready`:** registered, and equals the inverse of next-state `hold_full`.
  - It deasserts on the edge after an accept.
  - It reasserts on the edge after `hold` transfers to `sreg`.
- **FSM has two states, IDLE and SHIFT.**
  - IDLE, with `hold_full` set:
    - Load `sreg` from `hold` and clear `hold_full`.
    - Set `bit_cnt=0` and `div_cnt=0`.
    - Move to SHIFT.
  - SHIFT, each cycle:
    - If `div_cnt<DIV-1`, increment `div_cnt`.
    - Otherwise, set `div_cnt` to 0 and advance one bit:
      - MSB-first shifts left with 0 fill.
      - LSB-first shifts right with 0 fill.
      - Increment `bit_cnt`.
  - Last bit (`bit_cnt==WIDTH-1` and `div_cnt==DIV-1`), with `hold_full` set: reload `sreg` from `hold`, clear the counters and stay in SHIFT. There is no idle gap between words.
  - Last bit, with `hold` empty: go to IDLE.
- **`sout` in SHIFT:** `sreg[WIDTH-1]` when MSB-first, `sreg[0]` when LSB-first. `sout` is a flop updated alongside `sreg`, so the bit it shows matches `sframe`.
- **`sout` in IDLE:** `IDLE_LEVEL`.
- **Simultaneous events:** an accept on the same edge as a `hold` to `sreg` transfer cannot happen, because `din_ready` is already low while `hold_full` is set. No word is ever dropped or overwritten.
- **`din`** is sampled only at accept. Later changes to `din` have no effect.
- **Reset values** (asserted asynchronously while `rst_n` is low):
  - State is IDLE.
  - `hold_full=0`, `sreg=0`, counters 0.
  - `sout=IDLE_LEVEL`.
  - `din_ready=0`, `sframe=0`, `bit_strobe=0`, `word_done=0`, `busy=0`.
- **After reset:** `din_ready` rises on the first rising edge after `rst_n` deasserts.
- **Reset mid-word:** the partial word and any held word are discarded. `sout` returns to `IDLE_LEVEL` immediately.

## Timing
- **Latency:**
  - Accept on edge N.
  - `sreg` is loaded on edge N+1.
  - The first data bit appears on `sout` in the cycle after edge N+1, with `sframe=1` and `bit_strobe=1`.
- **Bit period:** each bit is held for exactly DIV cycles. A word occupies WIDTH×DIV cycles of `sframe` high.
- **`bit_strobe`:** asserted when `div_cnt==0` in SHIFT. With DIV=1 it is high every SHIFT cycle.
- **`word_done`:** asserted in the final SHIFT cycle of each word.
- **Back-to-back words:** `sframe` stays high continuously. `word_done` of word k and `bit_strobe` of word k+1 fall in adjacent cycles.
- **Throughput:** one word per WIDTH×DIV cycles when the source keeps `hold` full. WIDTH≥2 guarantees `din_ready` returns before the current word finishes.

## Test plan
- **Reset:** hold `rst_n=0` for 5 cycles, then release.
  - During reset: `sout=IDLE_LEVEL`, all other outputs 0.
  - `din_ready=1` one edge after release.
- **Single word, MSB-first, timing:** WIDTH=8, DIV=3, LSB_FIRST=0, send 0xA5.
  - `sout` = 1,0,1,0,0,1,0,1, each bit held 3 cycles.
  - `sframe` high for exactly 24 cycles; `bit_strobe` pulses 8 times, every 3 cycles.
  - `word_done` in cycle 24, then `sout=0`.
- **Single word, LSB-first with idle level:** WIDTH=8, DIV=1, LSB_FIRST=1, IDLE_LEVEL=1, send 0x3C.
  - `sout` = 0,0,1,1,1,1,0,0, then returns to 1.
  - First bit appears 2 edges after accept.
- **Back-to-back words:** WIDTH=8, DIV=1, with `din_valid` held high over 0xFF, 0x00, 0x81.
  - `sframe` high continuously for 24 cycles.
  - Serial stream is FF 00 81 with no gap.
  - Exactly 3 accepts; `din_ready` low while `hold` is full.
- **Reset mid-operation:** WIDTH=32, DIV=2, send 0xDEADBEEF and 0x12345678; pulse `rst_n` low during bit 10.
  - Outputs take reset values immediately.
  - After release, sending 0x00000001 produces exactly that word, with no residue from the discarded words.
- **Randomised backpressure:** WIDTH=16, DIV=4, random `din_valid` gaps, 200 words.
  - A scoreboard checks every accepted word is serialised in order, with no loss or duplication.
  - `busy` matches SHIFT state OR `hold_full` every cycle.
